// File: rtl/hci_package.sv
// Shared types for the HCI ECC scrubber: scrub FSM states and the Hsiao
// column generator used by the encoder and the decoder.
package hci_package;

  typedef enum logic [1:0] {WAIT, READ, CHECK, WRITE} hci_scrub_state_e;

  // Column idx of the H matrix: odd-weight (>=3) words, lowest weight first,
  // ascending value within a weight.
  function automatic int hsiao_col(input int ew, input int idx);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int w = 3; w <= ew; w += 2) begin
      for (int v = 0; v < (1 << ew); v++) begin
        if ($countones(v) == w) begin
          if (n == idx) res = v;
          n++;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hsiao_ecc.sv
// Hsiao SEC-DED encoder and decoder; codeword layout is {ecc, data}.
// Check bit j covers every data bit whose H column has bit j set.
module hsiao_ecc_enc
  import hci_package::*;
#(
  parameter int DW = 32,
  parameter int EW = 7
) (
  input  logic [DW-1:0]    data_i,
  output logic [DW+EW-1:0] code_o
);

  logic [EW-1:0] term [DW];
  logic [EW-1:0] ecc;

  for (genvar gi = 0; gi < DW; gi++) begin : g_col
    localparam logic [EW-1:0] COL = EW'(hsiao_col(EW, gi));
    assign term[gi] = data_i[gi] ? COL : '0;
  end

  always_comb begin
    ecc = '0;
    for (int i = 0; i < DW; i++) ecc = ecc ^ term[i];
  end

  assign code_o = {ecc, data_i};

endmodule

module hsiao_ecc_dec
  import hci_package::*;
#(
  parameter int DW = 32,
  parameter int EW = 7
) (
  input  logic [DW+EW-1:0] code_i,
  output logic [DW-1:0]    data_o,
  output logic [EW-1:0]    syndrome_o,
  output logic [1:0]       err_o
);

  logic [EW-1:0] term [DW];
  logic [DW-1:0] flip;

  for (genvar gi = 0; gi < DW; gi++) begin : g_col
    localparam logic [EW-1:0] COL = EW'(hsiao_col(EW, gi));
    assign term[gi] = code_i[gi] ? COL : '0;
    assign flip[gi] = (syndrome_o == COL);
  end

  always_comb begin
    syndrome_o = code_i[DW+EW-1:DW];
    for (int i = 0; i < DW; i++) syndrome_o = syndrome_o ^ term[i];
  end

  // Odd syndrome matching a data column or a single check bit is correctable;
  // anything else non-zero is reported as uncorrectable.
  always_comb begin
    err_o  = 2'b00;
    data_o = code_i[DW-1:0] ^ flip;
    if (syndrome_o != '0) begin
      if ((^syndrome_o) && ((|flip) || ($countones(syndrome_o) == 1)))
        err_o = 2'b01;
      else
        err_o = 2'b10;
    end
  end

endmodule

// File: rtl/hci_ecc_scrubber.sv
// Background scrubber for one Hsiao-protected TCDM bank. Core traffic always
// wins the bank; the scrubber reads, checks and repairs words in idle cycles.
module hci_ecc_scrubber
  import hci_package::*;
#(
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int AW = 10,
  parameter int IW = 16,
  parameter int CW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [IW-1:0]     interval_i,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic [AW-1:0]     core_add_i,
  input  logic              core_wen_i,
  input  logic [DW+EW-1:0]  core_wdata_i,
  output logic [DW+EW-1:0]  core_rdata_o,
  output logic              bank_req_o,
  output logic              bank_wen_o,
  output logic [AW-1:0]     bank_add_o,
  output logic [DW+EW-1:0]  bank_wdata_o,
  input  logic [DW+EW-1:0]  bank_rdata_i,
  output logic [AW-1:0]     scrub_addr_o,
  output logic [CW-1:0]     single_cnt_o,
  output logic [CW-1:0]     multi_cnt_o,
  output logic              multi_err_o,
  output logic [AW-1:0]     multi_err_add_o
);

  hci_scrub_state_e   state_reg;
  logic [IW-1:0]      interval_cnt_reg;
  logic [AW-1:0]      scrub_addr_reg;
  logic [AW-1:0]      wb_add_reg;
  logic [DW+EW-1:0]   wb_data_reg;
  logic [CW-1:0]      single_cnt_reg;
  logic [CW-1:0]      multi_cnt_reg;
  logic               multi_err_reg;
  logic [AW-1:0]      multi_err_add_reg;

  logic [DW-1:0]      dec_data;
  logic [EW-1:0]      dec_syndrome;
  logic [1:0]         dec_err;
  logic [DW+EW-1:0]   fix_code;
  logic               core_write;
  logic               hazard_check;
  logic               hazard_write;

  hsiao_ecc_dec #(.DW(DW), .EW(EW)) u_dec (
    .code_i     (bank_rdata_i),
    .data_o     (dec_data),
    .syndrome_o (dec_syndrome),
    .err_o      (dec_err)
  );

  hsiao_ecc_enc #(.DW(DW), .EW(EW)) u_enc (
    .data_i (dec_data),
    .code_o (fix_code)
  );

  // A core write to the word being repaired carries newer data than ours.
  assign core_write   = core_req_i & ~core_wen_i;
  assign hazard_check = core_write & (core_add_i == scrub_addr_reg);
  assign hazard_write = core_write & (core_add_i == wb_add_reg);

  always_comb begin
    bank_req_o   = core_req_i;
    bank_wen_o   = core_wen_i;
    bank_add_o   = core_add_i;
    bank_wdata_o = core_wdata_i;
    if (!rst_i && !core_req_i) begin
      if (state_reg == READ) begin
        bank_req_o   = 1'b1;
        bank_wen_o   = 1'b1;
        bank_add_o   = scrub_addr_reg;
        bank_wdata_o = '0;
      end else if (state_reg == WRITE) begin
        bank_req_o   = 1'b1;
        bank_wen_o   = 1'b0;
        bank_add_o   = wb_add_reg;
        bank_wdata_o = wb_data_reg;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= WAIT;
      interval_cnt_reg  <= '0;
      scrub_addr_reg    <= '0;
      wb_add_reg        <= '0;
      wb_data_reg       <= '0;
      single_cnt_reg    <= '0;
      multi_cnt_reg     <= '0;
      multi_err_reg     <= 1'b0;
      multi_err_add_reg <= '0;
    end else begin
      multi_err_reg <= 1'b0;
      case (state_reg)
        WAIT: begin
          if (!enable_i) begin
            interval_cnt_reg <= '0;
          end else if (interval_cnt_reg >= interval_i) begin
            interval_cnt_reg <= '0;
            state_reg        <= READ;
          end else begin
            interval_cnt_reg <= interval_cnt_reg + 1'b1;
          end
        end
        READ: if (!core_req_i) state_reg <= CHECK;
        // Read data is only valid this one cycle, so CHECK never stalls.
        CHECK: begin
          scrub_addr_reg <= scrub_addr_reg + 1'b1;
          state_reg      <= WAIT;
          if (dec_err[0]) begin
            if (single_cnt_reg != '1) single_cnt_reg <= single_cnt_reg + 1'b1;
            wb_add_reg  <= scrub_addr_reg;
            wb_data_reg <= fix_code;
            if (!hazard_check) state_reg <= WRITE;
          end else if (dec_err[1]) begin
            if (multi_cnt_reg != '1) multi_cnt_reg <= multi_cnt_reg + 1'b1;
            multi_err_reg     <= 1'b1;
            multi_err_add_reg <= scrub_addr_reg;
          end
        end
        WRITE: if (!core_req_i || hazard_write) state_reg <= WAIT;
        default: state_reg <= WAIT;
      endcase
    end
  end

  assign core_gnt_o      = core_req_i;
  assign core_rdata_o    = bank_rdata_i;
  assign scrub_addr_o    = scrub_addr_reg;
  assign single_cnt_o    = single_cnt_reg;
  assign multi_cnt_o     = multi_cnt_reg;
  assign multi_err_o     = multi_err_reg;
  assign multi_err_add_o = multi_err_add_reg;

endmodule

// File: tb/tb_hci_ecc_scrubber.sv
// Directed bench for hci_ecc_scrubber with a behavioural SRAM bank. Codewords
// below use H columns 0x07,0x0B,0x0D,0x0E,... for data bits 0,1,2,3,...
module tb_hci_ecc_scrubber;

  localparam int DW = 32;
  localparam int EW = 7;
  localparam int AW = 10;
  localparam int IW = 16;
  localparam int CW = 32;
  localparam int WW = DW + EW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic [IW-1:0] interval_i;
  logic          core_req_i;
  logic          core_gnt_o;
  logic [AW-1:0] core_add_i;
  logic          core_wen_i;
  logic [WW-1:0] core_wdata_i;
  logic [WW-1:0] core_rdata_o;
  logic          bank_req_o;
  logic          bank_wen_o;
  logic [AW-1:0] bank_add_o;
  logic [WW-1:0] bank_wdata_o;
  logic [WW-1:0] bank_rdata_i;
  logic [AW-1:0] scrub_addr_o;
  logic [CW-1:0] single_cnt_o;
  logic [CW-1:0] multi_cnt_o;
  logic          multi_err_o;
  logic [AW-1:0] multi_err_add_o;

  hci_ecc_scrubber #(.DW(DW), .EW(EW), .AW(AW), .IW(IW), .CW(CW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .interval_i      (interval_i),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_add_i      (core_add_i),
    .core_wen_i      (core_wen_i),
    .core_wdata_i    (core_wdata_i),
    .core_rdata_o    (core_rdata_o),
    .bank_req_o      (bank_req_o),
    .bank_wen_o      (bank_wen_o),
    .bank_add_o      (bank_add_o),
    .bank_wdata_o    (bank_wdata_o),
    .bank_rdata_i    (bank_rdata_i),
    .scrub_addr_o    (scrub_addr_o),
    .single_cnt_o    (single_cnt_o),
    .multi_cnt_o     (multi_cnt_o),
    .multi_err_o     (multi_err_o),
    .multi_err_add_o (multi_err_add_o)
  );

  always #5 clk_i = ~clk_i;

  logic [WW-1:0] mem [1 << AW];
  int            cyc = 0;
  int            rd_add_q[$];
  int            rd_cyc_q[$];
  int            wr_add_q[$];
  logic [WW-1:0] wr_data_q[$];
  int            pulse_cnt = 0;
  int            n_checks = 0;
  int            n_err = 0;

  // Bank model plus a record of every access the scrubber itself makes.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (bank_req_o) begin
      if (bank_wen_o) bank_rdata_i <= mem[bank_add_o];
      else            mem[bank_add_o] <= bank_wdata_o;
    end
    if (!rst_i && bank_req_o && !core_req_i) begin
      if (bank_wen_o) begin
        rd_add_q.push_back(int'(bank_add_o));
        rd_cyc_q.push_back(cyc);
      end else begin
        wr_add_q.push_back(int'(bank_add_o));
        wr_data_q.push_back(bank_wdata_o);
        $display("scrub write add=%0d data=%h", bank_add_o, bank_wdata_o);
      end
    end
    if (multi_err_o) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input int budget, input string tag);
    int k = 0;
    while (scrub_addr_o !== a && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 64'(scrub_addr_o == a), 64'd1);
  endtask

  // Stops in the cycle where the scrubber is driving a read of address a.
  task automatic wait_scrub_read(input logic [AW-1:0] a, input int budget, input string tag);
    int k = 0;
    while (!(bank_req_o && bank_wen_o && !core_req_i && bank_add_o == a) && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 64'(bank_add_o == a && !core_req_i), 64'd1);
  endtask

  initial begin
    int            bad;
    logic [AW-1:0] snap;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5]  = {7'h09, 32'h0000_0001};   // valid {09, 00000009} with data bit 3 flipped
    mem[9]  = {7'h00, 32'h0000_0003};   // two flipped data bits
    mem[12] = {7'h00, 32'h0000_0001};   // data bit 0 flipped
    mem[14] = {7'h01, 32'h0000_0000};   // check bit 0 flipped
    bank_rdata_i = '0;
    rst_i = 1'b1; enable_i = 1'b0; interval_i = 16'd4;
    core_req_i = 1'b0; core_add_i = '0; core_wen_i = 1'b1; core_wdata_i = '0;
    repeat (3) @(negedge clk_i);

    $display("step reset state");
    check("rst_scrub_addr", 64'(scrub_addr_o), 64'd0);
    check("rst_single", 64'(single_cnt_o), 64'd0);
    check("rst_multi", 64'(multi_cnt_o), 64'd0);
    check("rst_multi_err", 64'(multi_err_o), 64'd0);
    check("rst_multi_add", 64'(multi_err_add_o), 64'd0);
    check("rst_bank_req_idle", 64'(bank_req_o), 64'd0);
    core_req_i = 1'b1; core_add_i = 10'h55;
    #1;
    check("rst_bank_pass", 64'({core_gnt_o, bank_req_o, bank_wen_o, bank_add_o}), 64'({1'b1, 1'b1, 1'b1, 10'h55}));
    @(negedge clk_i);
    core_req_i = 1'b0;
    rst_i = 1'b0; enable_i = 1'b1;

    $display("step clean scan interval=4");
    for (int k = 0; k < 200 && rd_add_q.size() < 4; k++) @(negedge clk_i);
    check("scan_reads_seen", 64'(rd_add_q.size() >= 4), 64'd1);
    if (rd_add_q.size() >= 4) begin
      check("scan_add_seq", 64'({rd_add_q[0], rd_add_q[1], rd_add_q[2], rd_add_q[3]} == {32'd0, 32'd1, 32'd2, 32'd3}), 64'd1);
      check("scan_gap01", 64'(rd_cyc_q[1] - rd_cyc_q[0]), 64'd7);
      check("scan_gap23", 64'(rd_cyc_q[3] - rd_cyc_q[2]), 64'd7);
    end
    check("scan_counters", 64'({single_cnt_o, multi_cnt_o}), 64'd0);

    $display("step single error at 5");
    wait_addr(10'd6, 100, "single_reach_6");
    repeat (3) @(negedge clk_i);
    check("single_cnt_1", 64'(single_cnt_o), 64'd1);
    check("single_wr_count", 64'(wr_add_q.size()), 64'd1);
    if (wr_add_q.size() >= 1) begin
      check("single_wr_add", 64'(wr_add_q[0]), 64'd5);
      check("single_wr_data", 64'(wr_data_q[0]), 64'({7'h09, 32'h0000_0009}));
    end
    core_req_i = 1'b1; core_wen_i = 1'b1; core_add_i = 10'd5;
    @(negedge clk_i);
    core_req_i = 1'b0;
    check("single_core_read", 64'(core_rdata_o), 64'({7'h09, 32'h0000_0009}));

    $display("step multi error at 9");
    wait_addr(10'd10, 100, "multi_reach_10");
    repeat (2) @(negedge clk_i);
    check("multi_cnt_1", 64'(multi_cnt_o), 64'd1);
    check("multi_pulses", 64'(pulse_cnt), 64'd1);
    check("multi_err_add", 64'(multi_err_add_o), 64'd9);
    check("multi_no_write", 64'(wr_add_q.size()), 64'd1);
    check("multi_mem9_kept", 64'(mem[9]), 64'({7'h00, 32'h0000_0003}));

    $display("step core hold 100 cycles");
    wait_addr(10'd11, 100, "hold_reach_11");
    core_req_i = 1'b1; core_wen_i = 1'b1; core_add_i = 10'd100;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (!core_gnt_o || bank_add_o !== 10'd100 || bank_wen_o !== 1'b1) bad++;
    end
    check("hold_core_owns_bank", 64'(bad), 64'd0);
    check("hold_addr_stalled", 64'(scrub_addr_o), 64'd11);
    core_req_i = 1'b0;
    #1;
    check("hold_resume_read", 64'({bank_req_o, bank_wen_o, bank_add_o}), 64'({1'b1, 1'b1, 10'd11}));

    $display("step hazard at 12");
    wait_scrub_read(10'd12, 100, "hazard_read_12");
    @(negedge clk_i);
    core_req_i = 1'b1; core_wen_i = 1'b1; core_add_i = 10'd300;
    @(negedge clk_i);
    check("hazard_in_write_addr", 64'(scrub_addr_o), 64'd13);
    check("hazard_single_2", 64'(single_cnt_o), 64'd2);
    core_wen_i = 1'b0; core_add_i = 10'd12; core_wdata_i = {7'h0B, 32'h0000_0002};
    @(negedge clk_i);
    core_req_i = 1'b0; core_wen_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("hazard_no_write", 64'(wr_add_q.size()), 64'd1);
    check("hazard_mem12_core", 64'(mem[12]), 64'({7'h0B, 32'h0000_0002}));

    $display("step reset during write at 14");
    wait_scrub_read(10'd14, 100, "rst_read_14");
    @(negedge clk_i);
    core_req_i = 1'b1; core_add_i = 10'd300;
    @(negedge clk_i);
    check("rst_pre_single_3", 64'(single_cnt_o), 64'd3);
    rst_i = 1'b1; core_req_i = 1'b0; interval_i = 16'd0;
    #1;
    check("rst_blocks_write", 64'(bank_req_o), 64'd0);
    @(negedge clk_i);
    check("rst_mid_addr", 64'(scrub_addr_o), 64'd0);
    check("rst_mid_counters", 64'({single_cnt_o, multi_cnt_o}), 64'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_dropped_write", 64'(wr_add_q.size()), 64'd1);
    check("rst_mem14_bad", 64'(mem[14]), 64'({7'h01, 32'h0000_0000}));

    $display("step full pass interval=0 with wrap");
    wait_addr(10'd1023, 6000, "wrap_reach_1023");
    wait_addr(10'd0, 50, "wrap_reach_0");
    wait_scrub_read(10'd0, 20, "wrap_read_0");
    check("wrap_prev_read_1023", 64'(rd_add_q[rd_add_q.size()-1]), 64'd1023);
    check("pass_single_1", 64'(single_cnt_o), 64'd1);
    check("pass_multi_1", 64'(multi_cnt_o), 64'd1);
    check("pass_multi_add", 64'(multi_err_add_o), 64'd9);
    check("pass_mem14_fixed", 64'(mem[14]), 64'd0);
    check("pass_wr_count", 64'(wr_add_q.size()), 64'd2);

    $display("step enable low");
    enable_i = 1'b0;
    repeat (5) @(negedge clk_i);
    snap = scrub_addr_o;
    repeat (50) @(negedge clk_i);
    check("disable_holds", 64'(scrub_addr_o == snap), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
